// File: rtl/yutorina_spm_dp_pkg.sv
// Shared types and constants for the dual-port scratchpad.
// Strobe polarity, access direction and FSM encodings live here.
package yutorina_spm_dp_pkg;

    localparam int SPM_DATA_W = 32;
    localparam int SPM_DEPTH  = 4096;

    localparam logic ENABLE_ = 1'b0;
    localparam logic READ    = 1'b1;
    localparam logic WRITE   = 1'b0;

    typedef enum logic {
        SPM_ST_CLEAR = 1'b0,
        SPM_ST_RUN   = 1'b1
    } spm_state_e;

    function automatic int spm_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/yutorina_dpram_be.sv
// True dual-port RAM: read-only port A, byte-enable read/write port B.
// Port A sees port B writes of the same cycle (write-first merge).
module yutorina_dpram_be #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic                a_en,
    input  logic [ADDR_W-1:0]   a_addr,
    output logic [DATA_W-1:0]   a_rd_data,
    input  logic                b_re,
    input  logic                b_we,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [DATA_W-1:0]   b_wr_data,
    output logic [DATA_W-1:0]   b_rd_data
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] a_raw_q;
    logic [DATA_W-1:0] byp_data_q;
    logic [NB-1:0]     byp_be_q;
    logic [DATA_W-1:0] b_q;

    always_ff @(posedge clk) begin
        if (b_we) begin
            for (int k = 0; k < NB; k++) begin
                if (b_be[k]) begin
                    mem[b_addr][k*8 +: 8] <= b_wr_data[k*8 +: 8];
                end
            end
        end
    end

    // Array read is read-before-write; the bypass regs patch in new bytes.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            a_raw_q    <= '0;
            byp_data_q <= '0;
            byp_be_q   <= '0;
            b_q        <= '0;
        end else begin
            if (a_en) begin
                a_raw_q    <= mem[a_addr];
                byp_data_q <= b_wr_data;
                byp_be_q   <= (b_we && (b_addr == a_addr)) ? b_be : '0;
            end
            if (b_re) begin
                b_q <= mem[b_addr];
            end
        end
    end

    always_comb begin
        a_rd_data = a_raw_q;
        for (int k = 0; k < NB; k++) begin
            if (byp_be_q[k]) begin
                a_rd_data[k*8 +: 8] = byp_data_q[k*8 +: 8];
            end
        end
    end

    assign b_rd_data = b_q;

endmodule

// File: rtl/yutorina_spm_dp.sv
// Dual-port scratchpad: instruction read port, byte-enable data port,
// optional output register and a zeroing sweep after reset or clr_req.
module yutorina_spm_dp
    import yutorina_spm_dp_pkg::*;
#(
    parameter int DATA_W  = SPM_DATA_W,
    parameter int DEPTH   = SPM_DEPTH,
    parameter int ADDR_W  = spm_addr_w(DEPTH),
    parameter int OUT_REG = 0
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_as_,
    output logic                i_rdy,
    output logic [DATA_W-1:0]   i_rd_data,
    output logic                i_rd_vld,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_as_,
    input  logic                d_rw,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [DATA_W-1:0]   d_wr_data,
    output logic                d_rdy,
    output logic [DATA_W-1:0]   d_rd_data,
    output logic                d_rd_vld,
    input  logic                clr_req,
    output logic                init_done
);

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    spm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic run;
    logic i_in, d_in;
    logic i_acc, d_rd_acc, d_wr_acc;
    logic i_vld1_q, d_vld1_q;
    logic i_rng_q, d_rng_q;

    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W/8-1:0] b_be;
    logic [DATA_W-1:0] b_wr_data;
    logic [DATA_W-1:0] ram_a, ram_b;
    logic [DATA_W-1:0] i_d1, d_d1;

    assign run       = (state_q == SPM_ST_RUN);
    assign i_rdy     = run;
    assign d_rdy     = run;
    assign init_done = run;

    assign i_in = ({1'b0, i_addr} < DEPTH_X);
    assign d_in = ({1'b0, d_addr} < DEPTH_X);

    assign i_acc    = (i_as_ == ENABLE_) && run;
    assign d_rd_acc = (d_as_ == ENABLE_) && run && (d_rw == READ);
    assign d_wr_acc = (d_as_ == ENABLE_) && run && (d_rw == WRITE) && d_in;

    // The sweep borrows port B while the FSM is clearing.
    assign b_we      = !run || d_wr_acc;
    assign b_addr    = run ? d_addr : cnt_q;
    assign b_be      = run ? d_be : '1;
    assign b_wr_data = run ? d_wr_data : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SPM_ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = SPM_ST_RUN;
                    cnt_d   = '0;
                end
            end
            SPM_ST_RUN: begin
                if (clr_req) begin
                    state_d = SPM_ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SPM_ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q  <= SPM_ST_CLEAR;
            cnt_q    <= '0;
            i_vld1_q <= 1'b0;
            d_vld1_q <= 1'b0;
            i_rng_q  <= 1'b0;
            d_rng_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            i_vld1_q <= i_acc;
            d_vld1_q <= d_rd_acc;
            if (i_acc) i_rng_q <= i_in;
            if (d_rd_acc) d_rng_q <= d_in;
        end
    end

    yutorina_dpram_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .reset_    (reset_),
        .a_en      (i_acc && i_in),
        .a_addr    (i_addr),
        .a_rd_data (ram_a),
        .b_re      (d_rd_acc && d_in),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_be      (b_be),
        .b_wr_data (b_wr_data),
        .b_rd_data (ram_b)
    );

    // Range flags only move on accepted reads, so the data holds between reads.
    assign i_d1 = i_rng_q ? ram_a : '0;
    assign d_d1 = d_rng_q ? ram_b : '0;

    if (OUT_REG != 0) begin : g_oreg
        logic              i_vld2_q, d_vld2_q;
        logic [DATA_W-1:0] i_d2_q, d_d2_q;

        always_ff @(posedge clk or negedge reset_) begin
            if (!reset_) begin
                i_vld2_q <= 1'b0;
                d_vld2_q <= 1'b0;
                i_d2_q   <= '0;
                d_d2_q   <= '0;
            end else begin
                i_vld2_q <= i_vld1_q;
                d_vld2_q <= d_vld1_q;
                if (i_vld1_q) i_d2_q <= i_d1;
                if (d_vld1_q) d_d2_q <= d_d1;
            end
        end

        assign i_rd_vld  = i_vld2_q;
        assign d_rd_vld  = d_vld2_q;
        assign i_rd_data = i_d2_q;
        assign d_rd_data = d_d2_q;
    end else begin : g_nreg
        assign i_rd_vld  = i_vld1_q;
        assign d_rd_vld  = d_vld1_q;
        assign i_rd_data = i_d1;
        assign d_rd_data = d_d1;
    end

endmodule

// File: tb/tb_yutorina_spm_dp.sv
// Bench for yutorina_spm_dp: two instances (OUT_REG 0 and 1, DEPTH 12)
// driven identically and checked against a transaction-level model.
module tb_yutorina_spm_dp;

    localparam int DEP = 12;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          reset_ = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_as_ = 1'b1;
    logic [AW-1:0] d_addr = '0;
    logic          d_as_ = 1'b1;
    logic          d_rw = 1'b1;
    logic [3:0]    d_be = '0;
    logic [31:0]   d_wr_data = '0;
    logic          clr_req = 1'b0;

    logic          i_rdy_w  [2];
    logic [31:0]   i_data_w [2];
    logic          i_vld_w  [2];
    logic          d_rdy_w  [2];
    logic [31:0]   d_data_w [2];
    logic          d_vld_w  [2];
    logic          done_w   [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        yutorina_spm_dp #(
            .DATA_W  (32),
            .DEPTH   (DEP),
            .OUT_REG (g)
        ) u_dut (
            .clk       (clk),
            .reset_    (reset_),
            .i_addr    (i_addr),
            .i_as_     (i_as_),
            .i_rdy     (i_rdy_w[g]),
            .i_rd_data (i_data_w[g]),
            .i_rd_vld  (i_vld_w[g]),
            .d_addr    (d_addr),
            .d_as_     (d_as_),
            .d_rw      (d_rw),
            .d_be      (d_be),
            .d_wr_data (d_wr_data),
            .d_rdy     (d_rdy_w[g]),
            .d_rd_data (d_data_w[g]),
            .d_rd_vld  (d_vld_w[g]),
            .clr_req   (clr_req),
            .init_done (done_w[g])
        );
    end

    typedef struct {
        int          ae;
        logic [31:0] data;
    } rd_t;

    logic [31:0] mem [DEP];
    rd_t         qi[$];
    rd_t         qd[$];
    logic [31:0] last_i [2];
    logic [31:0] last_d [2];
    int          clr_rem;
    int          cyc;
    int          checks;
    int          errs;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic check();
        logic ev;
        logic rdy;
        rdy = (clr_rem == 0);
        for (int k = 0; k < 2; k++) begin
            ev = 1'b0;
            foreach (qi[j]) if (qi[j].ae == cyc - k) begin
                ev = 1'b1;
                last_i[k] = qi[j].data;
            end
            chk($sformatf("i_vld%0d@%0d", k, cyc), {31'b0, i_vld_w[k]}, {31'b0, ev});
            chk($sformatf("i_data%0d@%0d", k, cyc), i_data_w[k], last_i[k]);
            ev = 1'b0;
            foreach (qd[j]) if (qd[j].ae == cyc - k) begin
                ev = 1'b1;
                last_d[k] = qd[j].data;
            end
            chk($sformatf("d_vld%0d@%0d", k, cyc), {31'b0, d_vld_w[k]}, {31'b0, ev});
            chk($sformatf("d_data%0d@%0d", k, cyc), d_data_w[k], last_d[k]);
            chk($sformatf("i_rdy%0d@%0d", k, cyc), {31'b0, i_rdy_w[k]}, {31'b0, rdy});
            chk($sformatf("d_rdy%0d@%0d", k, cyc), {31'b0, d_rdy_w[k]}, {31'b0, rdy});
            chk($sformatf("done%0d@%0d", k, cyc), {31'b0, done_w[k]}, {31'b0, rdy});
        end
        while (qi.size() > 0 && qi[0].ae < cyc - 1) void'(qi.pop_front());
        while (qd.size() > 0 && qd[0].ae < cyc - 1) void'(qd.pop_front());
    endtask

    // Apply the upcoming edge to the model, clock it, then compare.
    task automatic step();
        logic rdy;
        rd_t  r;
        rdy = (clr_rem == 0);
        if (rdy && !d_as_ && !d_rw && int'(d_addr) < DEP) begin
            for (int b = 0; b < 4; b++)
                if (d_be[b]) mem[d_addr][b*8 +: 8] = d_wr_data[b*8 +: 8];
        end
        if (rdy && !i_as_) begin
            r.ae   = cyc + 1;
            r.data = (int'(i_addr) < DEP) ? mem[i_addr] : 32'h0;
            qi.push_back(r);
        end
        if (rdy && !d_as_ && d_rw) begin
            r.ae   = cyc + 1;
            r.data = (int'(d_addr) < DEP) ? mem[d_addr] : 32'h0;
            qd.push_back(r);
        end
        if (clr_rem > 0) clr_rem--;
        else if (clr_req) begin
            clr_rem = DEP;
            foreach (mem[j]) mem[j] = 32'h0;
        end
        @(posedge clk);
        cyc++;
        #1;
        check();
    endtask

    task automatic idle();
        i_as_   = 1'b1;
        d_as_   = 1'b1;
        clr_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        #1;
        qi.delete();
        qd.delete();
        for (int k = 0; k < 2; k++) begin
            last_i[k] = '0;
            last_d[k] = '0;
        end
        clr_rem = DEP;
        foreach (mem[j]) mem[j] = 32'h0;
        check();
        repeat (2) @(posedge clk);
        #1;
        reset_ = 1'b1;
    endtask

    task automatic dwr(input int a, input logic [31:0] v, input logic [3:0] be);
        d_as_ = 1'b0; d_rw = 1'b0; d_addr = AW'(a);
        d_wr_data = v; d_be = be;
    endtask

    task automatic drd(input int a);
        d_as_ = 1'b0; d_rw = 1'b1; d_addr = AW'(a);
    endtask

    task automatic ird(input int a);
        i_as_ = 1'b0; i_addr = AW'(a);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errs = 0; cyc = 0;
        do_reset();
        repeat (DEP) step();
        chk("init_done_after_clear", {31'b0, done_w[0]}, 32'h1);

        for (int a = 0; a < DEP; a++) begin
            ird(a); drd(DEP - 1 - a); step();
        end
        idle(); step(); step();

        dwr(3, 32'h11223344, 4'hF); step();
        dwr(3, 32'hAABBCCDD, 4'b0101); step();
        drd(3); step();
        chk("be_merge_or0", d_data_w[0], 32'h11BB33DD);
        chk("be_vld_or0", {31'b0, d_vld_w[0]}, 32'h1);
        idle(); step();
        chk("be_merge_or1", d_data_w[1], 32'h11BB33DD);
        chk("be_vld_or1", {31'b0, d_vld_w[1]}, 32'h1);

        dwr(5, 32'h0, 4'hF); step();
        ird(5); dwr(5, 32'hDEADBEEF, 4'b1100); step();
        chk("collide_or0", i_data_w[0], 32'hDEAD0000);
        idle(); step();
        chk("collide_or1", i_data_w[1], 32'hDEAD0000);

        for (int a = 0; a < 8; a++) begin
            dwr(a + 2, $urandom, 4'hF); step();
        end
        for (int a = 0; a < 8; a++) begin
            ird(a); drd(a + 2); step();
        end
        idle(); step(); step();

        drd(3); step();
        idle(); clr_req = 1'b1; step();
        clr_req = 1'b0;
        ird(3); drd(3);
        for (int n = 0; n < DEP + 4; n++) begin
            if (clr_rem == 0) break;
            step();
        end
        step();
        idle(); step();
        chk("post_clear_i", i_data_w[1], 32'h0);
        chk("post_clear_d", d_data_w[1], 32'h0);
        for (int a = 0; a < DEP; a++) begin
            ird(a); drd(a); step();
        end
        idle(); step(); step();

        dwr(11, 32'hCAFEF00D, 4'hF); step();
        dwr(13, 32'h12345678, 4'hF); step();
        drd(13); ird(13); step();
        chk("oor_d_or0", d_data_w[0], 32'h0);
        chk("oor_vld_or0", {31'b0, d_vld_w[0]}, 32'h1);
        drd(11); ird(11); step();
        chk("edge_d_or0", d_data_w[0], 32'hCAFEF00D);
        idle(); step(); step();

        for (int n = 0; n < 400; n++) begin
            i_as_     = ($urandom_range(0, 2) == 0);
            i_addr    = AW'($urandom_range(0, 15));
            d_as_     = ($urandom_range(0, 2) == 0);
            d_rw      = $urandom_range(0, 1) == 1;
            d_addr    = AW'($urandom_range(0, 15));
            d_be      = 4'($urandom_range(0, 15));
            d_wr_data = $urandom;
            clr_req   = ($urandom_range(0, 63) == 0);
            step();
        end
        idle(); repeat (DEP + 2) step();

        drd(2); ird(4); step();
        idle();
        #2;
        do_reset();
        repeat (DEP + 3) step();
        chk("restart_done", {31'b0, done_w[1]}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
